fg_bbox_tracker: RTL and testbench

Downstream consumer of the adaptive background-subtraction stage. Takes the per-pixel foreground flag stream, rebuilds raster (x,y) coordinates, and accumulates a per-frame foreground pixel count and bounding box. At end of frame it publishes min/max X/Y, the count and an object-present flag, used by the overlay/box-draw stage and the UART status reporter.

---
 rtl/fg_bbox_tracker_if.sv | 33 +++
 rtl/fg_bbox_tracker.sv | 146 ++++++++++++++
 tb/tb_fg_bbox_tracker.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fg_bbox_tracker_if.sv
// Pixel-stream inputs and published bounding-box results of the foreground
// bbox tracker, with a master modport for the source and a slave modport for the tracker.
interface fg_bbox_tracker_if #(
  parameter int X_W   = 9,
  parameter int Y_W   = 8,
  parameter int CNT_W = 17
);
  logic             enable;
  logic             frame_start;
  logic             pix_valid;
  logic             fg_flag;
  logic [X_W-1:0]   bbox_x_min;
  logic [X_W-1:0]   bbox_x_max;
  logic [Y_W-1:0]   bbox_y_min;
  logic [Y_W-1:0]   bbox_y_max;
  logic [CNT_W-1:0] fg_count;
  logic             bbox_valid;
  logic             short_frame;
  logic             result_strobe;
  logic             busy;

  modport master (
    output enable, frame_start, pix_valid, fg_flag,
    input  bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
    input  fg_count, bbox_valid, short_frame, result_strobe, busy
  );

  modport slave (
    input  enable, frame_start, pix_valid, fg_flag,
    output bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
    output fg_count, bbox_valid, short_frame, result_strobe, busy
  );
endinterface

// File: rtl/fg_bbox_tracker.sv
// Rebuilds raster coordinates from the foreground flag stream and publishes a
// per-frame foreground count and bounding box at end of frame.
//
// state   | meaning
// IDLE    | waiting for frame_start; pix_valid ignored
// ACCUM   | accumulating count/box over the active frame
// PUBLISH | last pixel taken; outputs load on the next enabled cycle
module fg_bbox_tracker #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int CNT_W      = 17,
  parameter int MIN_PIXELS = 64
) (
  input  logic              clk,
  input  logic              rst,
  fg_bbox_tracker_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCUM   = 2'd1;
  localparam logic [1:0] PUBLISH = 2'd2;

  localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state, state_nxt;
  logic [X_W-1:0]   x, x_nxt, min_x, min_x_nxt, max_x, max_x_nxt;
  logic [Y_W-1:0]   y, y_nxt, min_y, min_y_nxt, max_y, max_y_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [X_W-1:0]   bx, bmin_x, bmax_x;
  logic [Y_W-1:0]   by, bmin_y, bmax_y;
  logic [CNT_W-1:0] bcnt;
  logic             restart, take, last, publish, pub_valid;

  logic [X_W-1:0]   o_x_min, o_x_max;
  logic [Y_W-1:0]   o_y_min, o_y_max;
  logic [CNT_W-1:0] o_count;
  logic             o_valid, o_short, o_strobe;

  always_comb begin
    restart = bus.enable & bus.frame_start;
    take    = bus.enable & bus.pix_valid & (restart | (state == ACCUM));
    publish = bus.enable & ((state == PUBLISH) | ((state == ACCUM) & bus.frame_start));

    // A restart means the coincident pixel sees a freshly cleared frame at (0,0).
    bx     = restart ? '0 : x;
    by     = restart ? '0 : y;
    bmin_x = restart ? X_LAST : min_x;
    bmax_x = restart ? '0 : max_x;
    bmin_y = restart ? Y_LAST : min_y;
    bmax_y = restart ? '0 : max_y;
    bcnt   = restart ? '0 : cnt;

    last = take & (bx == X_LAST) & (by == Y_LAST);

    x_nxt     = bx;
    y_nxt     = by;
    min_x_nxt = bmin_x;
    max_x_nxt = bmax_x;
    min_y_nxt = bmin_y;
    max_y_nxt = bmax_y;
    cnt_nxt   = bcnt;

    if (take) begin
      if (bx == X_LAST) begin
        x_nxt = '0;
        y_nxt = (by == Y_LAST) ? '0 : by + Y_W'(1);
      end else begin
        x_nxt = bx + X_W'(1);
      end
      if (bus.fg_flag) begin
        if (bcnt != CNT_MAX) cnt_nxt = bcnt + CNT_W'(1);
        if (bx < bmin_x) min_x_nxt = bx;
        if (bx > bmax_x) max_x_nxt = bx;
        if (by < bmin_y) min_y_nxt = by;
        if (by > bmax_y) max_y_nxt = by;
      end
    end

    state_nxt = state;
    if (bus.enable) begin
      if (last)                  state_nxt = PUBLISH;
      else if (restart)          state_nxt = ACCUM;
      else if (state == PUBLISH) state_nxt = IDLE;
    end

    pub_valid = (32'(cnt) >= MIN_PIXELS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      min_x    <= X_LAST;
      max_x    <= '0;
      min_y    <= Y_LAST;
      max_y    <= '0;
      cnt      <= '0;
      o_x_min  <= '0;
      o_x_max  <= '0;
      o_y_min  <= '0;
      o_y_max  <= '0;
      o_count  <= '0;
      o_valid  <= 1'b0;
      o_short  <= 1'b0;
      o_strobe <= 1'b0;
    end else begin
      state    <= state_nxt;
      x        <= x_nxt;
      y        <= y_nxt;
      min_x    <= min_x_nxt;
      max_x    <= max_x_nxt;
      min_y    <= min_y_nxt;
      max_y    <= max_y_nxt;
      cnt      <= cnt_nxt;
      o_strobe <= 1'b0;
      // Publish uses the pre-restart accumulators, so a truncated frame reports its partial result.
      if (publish) begin
        o_x_min  <= pub_valid ? min_x : '0;
        o_x_max  <= pub_valid ? max_x : '0;
        o_y_min  <= pub_valid ? min_y : '0;
        o_y_max  <= pub_valid ? max_y : '0;
        o_count  <= cnt;
        o_valid  <= pub_valid;
        o_short  <= (state == ACCUM);
        o_strobe <= 1'b1;
      end
    end
  end

  assign bus.bbox_x_min    = o_x_min;
  assign bus.bbox_x_max    = o_x_max;
  assign bus.bbox_y_min    = o_y_min;
  assign bus.bbox_y_max    = o_y_max;
  assign bus.fg_count      = o_count;
  assign bus.bbox_valid    = o_valid;
  assign bus.short_frame   = o_short;
  assign bus.result_strobe = o_strobe;
  assign bus.busy          = (state == ACCUM);

endmodule

// File: tb/tb_fg_bbox_tracker.sv
// Directed bench for fg_bbox_tracker on an 8x4 image; a second instance with a
// 5-bit counter checks count saturation.
module tb_fg_bbox_tracker;

  logic clk = 1'b0;
  logic rst;
  logic enable, frame_start, pix_valid, fg_flag;

  always #5 clk = ~clk;

  fg_bbox_tracker_if #(.X_W(3), .Y_W(2), .CNT_W(6)) bus0 ();
  fg_bbox_tracker_if #(.X_W(3), .Y_W(2), .CNT_W(5)) bus1 ();

  assign bus0.enable      = enable;
  assign bus0.frame_start = frame_start;
  assign bus0.pix_valid   = pix_valid;
  assign bus0.fg_flag     = fg_flag;
  assign bus1.enable      = enable;
  assign bus1.frame_start = frame_start;
  assign bus1.pix_valid   = pix_valid;
  assign bus1.fg_flag     = fg_flag;

  fg_bbox_tracker #(.IMG_W(8), .IMG_H(4), .X_W(3), .Y_W(2), .CNT_W(6), .MIN_PIXELS(2))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fg_bbox_tracker #(.IMG_W(8), .IMG_H(4), .X_W(3), .Y_W(2), .CNT_W(5), .MIN_PIXELS(2))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp  = 0;
  int n_fail = 0;
  int strobes = 0;
  int s0;

  // Pixel index = y*8 + x.
  localparam logic [31:0] M1 = (32'd1 << 10) | (32'd1 << 29) | (32'd1 << 19);
  localparam logic [31:0] M2 = (32'd1 << 7);
  localparam logic [31:0] MB = (32'd1 << 0) | (32'd1 << 31);
  localparam logic [17:0] EXP1 = {3'd2, 3'd5, 2'd1, 2'd3, 6'd3, 1'b1, 1'b0};

  always @(negedge clk) if (bus0.result_strobe === 1'b1) strobes++;

  // {x_min, x_max, y_min, y_max, count, valid, short}
  function automatic logic [17:0] res0();
    return {bus0.bbox_x_min, bus0.bbox_x_max, bus0.bbox_y_min, bus0.bbox_y_max,
            bus0.fg_count, bus0.bbox_valid, bus0.short_frame};
  endfunction

  task automatic cyc(input logic en, input logic fs, input logic pv, input logic fg);
    enable = en; frame_start = fs; pix_valid = pv; fg_flag = fg;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pixels(input logic [31:0] mask, input int first, input int n,
                            input logic fs_first, input logic toggle);
    logic fs;
    for (int i = first; i < first + n; i++) begin
      fs = fs_first && (i == first);
      if (toggle) cyc(1'b0, fs, 1'b1, mask[i]);
      cyc(1'b1, fs, 1'b1, mask[i]);
    end
  endtask

  task automatic idle(input int n, input logic toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (res0() !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", res0(), 18'd0);
    end
    n_cmp++;
    if ({bus0.busy, bus0.result_strobe} !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy_strobe: got %b want 00", {bus0.busy, bus0.result_strobe});
    end
    rst = 1'b0;
    idle(2, 1'b0);
  endtask

  task automatic test_single_object();
    s0 = strobes;
    run_pixels(M1, 0, 31, 1'b1, 1'b0);
    n_cmp++;
    if (bus0.busy !== 1'b1) begin
      n_fail++; $display("FAIL accum_busy: got %b want 1", bus0.busy);
    end
    run_pixels(M1, 31, 1, 1'b0, 1'b0);
    n_cmp++;
    if ({bus0.busy, bus0.result_strobe} !== 2'b00) begin
      n_fail++; $display("FAIL last_pixel_state: got busy,strobe=%b want 00", {bus0.busy, bus0.result_strobe});
    end
    idle(1, 1'b0);
    n_cmp++;
    if (bus0.result_strobe !== 1'b1) begin
      n_fail++; $display("FAIL strobe_latency: got %b want 1", bus0.result_strobe);
    end
    n_cmp++;
    if (res0() !== EXP1) begin
      n_fail++; $display("FAIL single_object_result: got %h want %h", res0(), EXP1);
    end
    idle(3, 1'b0);
    n_cmp++;
    if (res0() !== EXP1 || bus0.result_strobe !== 1'b0) begin
      n_fail++; $display("FAIL single_object_hold: got %h strobe %b want %h strobe 0", res0(), bus0.result_strobe, EXP1);
    end
    n_cmp++;
    if (strobes - s0 !== 1) begin
      n_fail++; $display("FAIL single_object_strobes: got %0d want 1", strobes - s0);
    end
  endtask

  task automatic test_below_min();
    s0 = strobes;
    run_pixels(M2, 0, 32, 1'b1, 1'b0);
    idle(3, 1'b0);
    n_cmp++;
    if (res0() !== {3'd0, 3'd0, 2'd0, 2'd0, 6'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL below_min_result: got %h want %h", res0(), {3'd0, 3'd0, 2'd0, 2'd0, 6'd1, 1'b0, 1'b0});
    end
    n_cmp++;
    if (strobes - s0 !== 1) begin
      n_fail++; $display("FAIL below_min_strobes: got %0d want 1", strobes - s0);
    end
  endtask

  task automatic test_full_frame();
    s0 = strobes;
    run_pixels(32'hFFFF_FFFF, 0, 32, 1'b1, 1'b0);
    idle(3, 1'b0);
    n_cmp++;
    if (res0() !== {3'd0, 3'd7, 2'd0, 2'd3, 6'd32, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL full_frame_result: got %h want %h", res0(), {3'd0, 3'd7, 2'd0, 2'd3, 6'd32, 1'b1, 1'b0});
    end
    n_cmp++;
    if ({bus1.fg_count, bus1.bbox_valid} !== {5'd31, 1'b1}) begin
      n_fail++; $display("FAIL saturated_count: got %0d valid %b want 31 valid 1", bus1.fg_count, bus1.bbox_valid);
    end
    n_cmp++;
    if (strobes - s0 !== 1) begin
      n_fail++; $display("FAIL full_frame_strobes: got %0d want 1", strobes - s0);
    end
  endtask

  task automatic test_truncated();
    s0 = strobes;
    run_pixels(32'd1 << 1, 0, 10, 1'b1, 1'b0);
    n_cmp++;
    if (strobes - s0 !== 0 || bus0.busy !== 1'b1) begin
      n_fail++; $display("FAIL truncated_pre: got strobes %0d busy %b want 0 busy 1", strobes - s0, bus0.busy);
    end
    run_pixels(M1, 0, 1, 1'b1, 1'b0);
    n_cmp++;
    if ({bus0.result_strobe, bus0.busy} !== 2'b11) begin
      n_fail++; $display("FAIL truncated_strobe: got strobe,busy=%b want 11", {bus0.result_strobe, bus0.busy});
    end
    n_cmp++;
    if (res0() !== {3'd0, 3'd0, 2'd0, 2'd0, 6'd1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL truncated_result: got %h want %h", res0(), {3'd0, 3'd0, 2'd0, 2'd0, 6'd1, 1'b0, 1'b1});
    end
    run_pixels(M1, 1, 31, 1'b0, 1'b0);
    idle(3, 1'b0);
    n_cmp++;
    if (res0() !== EXP1) begin
      n_fail++; $display("FAIL after_truncate_result: got %h want %h", res0(), EXP1);
    end
    n_cmp++;
    if (strobes - s0 !== 2) begin
      n_fail++; $display("FAIL truncated_strobes: got %0d want 2", strobes - s0);
    end
  endtask

  task automatic test_back_to_back();
    s0 = strobes;
    run_pixels(M1, 0, 32, 1'b1, 1'b0);
    run_pixels(MB, 0, 1, 1'b1, 1'b0);
    n_cmp++;
    if ({bus0.result_strobe, bus0.busy} !== 2'b11 || res0() !== EXP1) begin
      n_fail++; $display("FAIL b2b_first: got strobe,busy=%b res %h want 11 res %h", {bus0.result_strobe, bus0.busy}, res0(), EXP1);
    end
    run_pixels(MB, 1, 31, 1'b0, 1'b0);
    idle(3, 1'b0);
    n_cmp++;
    if (res0() !== {3'd0, 3'd7, 2'd0, 2'd3, 6'd2, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second: got %h want %h", res0(), {3'd0, 3'd7, 2'd0, 2'd3, 6'd2, 1'b1, 1'b0});
    end
    n_cmp++;
    if (strobes - s0 !== 2) begin
      n_fail++; $display("FAIL b2b_strobes: got %0d want 2", strobes - s0);
    end
  endtask

  task automatic test_enable_toggle();
    // Land on a different result first so the toggled frame must really republish.
    run_pixels(M2, 0, 32, 1'b1, 1'b0);
    idle(3, 1'b0);
    s0 = strobes;
    run_pixels(M1, 0, 32, 1'b1, 1'b1);
    idle(4, 1'b1);
    n_cmp++;
    if (res0() !== EXP1) begin
      n_fail++; $display("FAIL toggle_result: got %h want %h", res0(), EXP1);
    end
    n_cmp++;
    if (strobes - s0 !== 1) begin
      n_fail++; $display("FAIL toggle_strobe_width: got %0d high cycles want 1", strobes - s0);
    end
  endtask

  task automatic test_rst_midframe();
    s0 = strobes;
    run_pixels(32'hFFFF_FFFF, 0, 20, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    n_cmp++;
    if (res0() !== 18'd0 || bus0.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h busy %b want 0 busy 0", res0(), bus0.busy);
    end
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b0);
    n_cmp++;
    if (strobes - s0 !== 0 || bus0.busy !== 1'b0 || res0() !== 18'd0) begin
      n_fail++; $display("FAIL idle_ignores_pixels: got strobes %0d busy %b res %h want 0 0 0", strobes - s0, bus0.busy, res0());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; fg_flag = 1'b0;
    test_reset();
    test_single_object();
    test_below_min();
    test_full_frame();
    test_truncated();
    test_back_to_back();
    test_enable_toggle();
    test_rst_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
